// File: rtl/keypad_scanner_if.sv
// Keypad-side and decoder-side signals of the 4x3 keypad scanner.
// The scanner takes the master modport; the keypad/decoder/lock side takes the slave modport.
interface keypad_scanner_if;
   logic [2:0] col_i;
   logic [3:0] row_o;
   logic [7:0] conv8;
   logic       key_valid;
   logic       key_held;

   modport master (
      input  col_i,
      output row_o,
      output conv8,
      output key_valid,
      output key_held
   );

   modport slave (
      output col_i,
      input  row_o,
      input  conv8,
      input  key_valid,
      input  key_held
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: row rotation, column synchroniser, per-frame single-key
// detection and a frame-rate debounce FSM producing the {col,row} one-hot scan code.
module keypad_scanner #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 8,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   keypad_scanner_if.master kp
);

   localparam int              DB_W      = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      PRESSED  = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   logic [2:0]       col_s1_q, col_s1_d;
   logic [2:0]       col_s2_q, col_s2_d;
   logic [CNT_W-1:0] slot_q, slot_d;
   logic [3:0]       row_q, row_d;
   logic [1:0]       hits_q, hits_d;
   logic [7:0]       code_q, code_d;
   state_t           state_q, state_d;
   logic [7:0]       cand_q, cand_d;
   logic [DB_W-1:0]  cnt_q, cnt_d;
   logic [7:0]       conv8_q, conv8_d;
   logic             valid_q, valid_d;
   logic             held_q, held_d;

   logic [2:0]      colh;
   logic            sample;
   logic            frame_end;
   logic [1:0]      sample_hits;
   logic [2:0]      hit_sum;
   logic [1:0]      frame_hits;
   logic [7:0]      sample_code;
   logic [7:0]      acc_code;
   logic [7:0]      frame_code;
   logic [DB_W-1:0] cnt_inc;

   // Column synchroniser, slot counter, row rotation and per-frame contact accumulation.
   // hits saturates at 2 so that any multi-press or ghost pattern collapses to "no key".
   always_comb begin
      col_s1_d    = kp.col_i;
      col_s2_d    = col_s1_q;
      colh        = ~col_s2_q;
      sample      = (slot_q == SLOT_LAST);
      frame_end   = sample && !row_q[3];
      sample_hits = 2'(colh[0]) + 2'(colh[1]) + 2'(colh[2]);
      sample_code = {1'b0, colh[0], colh[1], colh[2], ~row_q};
      hit_sum     = {1'b0, hits_q} + {1'b0, sample_hits};
      frame_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      acc_code    = (sample_hits == 2'd1) ? sample_code : code_q;
      frame_code  = (frame_hits == 2'd1) ? acc_code : 8'h00;

      slot_d = slot_q + CNT_W'(1);
      row_d  = row_q;
      hits_d = hits_q;
      code_d = code_q;
      if (sample) begin
         slot_d = '0;
         row_d  = {row_q[2:0], row_q[3]};
         hits_d = frame_hits;
         code_d = acc_code;
      end
      if (frame_end) begin
         hits_d = 2'd0;
         code_d = 8'h00;
      end
   end

   // Debounce FSM, stepped only on frame ends; the counter saturates at its target.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      conv8_d = conv8_q;
      valid_d = 1'b0;
      cnt_inc = (cnt_q >= DB_TARGET) ? cnt_q : cnt_q + DB_W'(1);

      if (frame_end) begin
         case (state_q)
            IDLE: begin
               if (frame_code != 8'h00) begin
                  cand_d  = frame_code;
                  cnt_d   = DB_W'(1);
                  state_d = PRESS_DB;
               end
            end
            PRESS_DB: begin
               if (frame_code == 8'h00) begin
                  state_d = IDLE;
               end else if (frame_code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DB_TARGET) begin
                     conv8_d = cand_q;
                     valid_d = 1'b1;
                     state_d = PRESSED;
                  end
               end else begin
                  cand_d = frame_code;
                  cnt_d  = DB_W'(1);
               end
            end
            PRESSED: begin
               if (frame_code != conv8_q) begin
                  cnt_d   = DB_W'(1);
                  state_d = REL_DB;
               end
            end
            REL_DB: begin
               if (frame_code == conv8_q) begin
                  state_d = PRESSED;
               end else begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= DB_TARGET) begin
                     conv8_d = 8'h00;
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end

      held_d = (conv8_d != 8'h00);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_s1_q <= 3'b111;
         col_s2_q <= 3'b111;
         slot_q   <= '0;
         row_q    <= 4'b1110;
         hits_q   <= 2'd0;
         code_q   <= 8'h00;
         state_q  <= IDLE;
         cand_q   <= 8'h00;
         cnt_q    <= '0;
         conv8_q  <= 8'h00;
         valid_q  <= 1'b0;
         held_q   <= 1'b0;
      end else begin
         col_s1_q <= col_s1_d;
         col_s2_q <= col_s2_d;
         slot_q   <= slot_d;
         row_q    <= row_d;
         hits_q   <= hits_d;
         code_q   <= code_d;
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         conv8_q  <= conv8_d;
         valid_q  <= valid_d;
         held_q   <= held_d;
      end
   end

   assign kp.row_o     = row_q;
   assign kp.conv8     = conv8_q;
   assign kp.key_valid = valid_q;
   assign kp.key_held  = held_q;

endmodule
